wait_state_memory: RTL

// Parametrised single-port data memory for the core's memory bus. Successor to the fixed
// 8-bit shared-data-bus memory. Adds:
// - split read/write data buses
// - configurable wait states and depth
// - explicit mem_ready/mem_err completion handshake

---
 rtl/wait_state_memory_if.sv | 25 ++
 rtl/wait_state_memory.sv | 104 ++++++++++
 2 files changed

// File: rtl/wait_state_memory_if.sv
// Memory bus bundle between the load/store unit (master) and wait_state_memory (slave).
// Carries split read/write data plus the ready/err/busy completion handshake.
interface wait_state_memory_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mrd;
  logic                  mwr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  mem_err;
  logic                  mem_busy;

  modport master (
    output mem_addr, mem_wdata, mrd, mwr,
    input  mem_rdata, mem_ready, mem_err, mem_busy
  );

  modport slave (
    input  mem_addr, mem_wdata, mrd, mwr,
    output mem_rdata, mem_ready, mem_err, mem_busy
  );
endinterface

// File: rtl/wait_state_memory.sv
// Single-port data memory with configurable wait states, one access in flight,
// and a registered mem_ready/mem_err completion pulse.
module wait_state_memory #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  wait_state_memory_if.slave bus
);

  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [7:0]          WAIT_L  = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_accept;
  logic                  w_req_bad;
  logic [7:0]            r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_wr;
  logic                  r_bad;
  logic                  r_ready;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // Illegal (both strobes) or out-of-range requests complete with an error and never touch the array.
  assign w_req_bad = (bus.mrd & bus.mwr) | ({1'b0, bus.mem_addr} >= DEPTH_L);

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((bus.mrd | bus.mwr) && !r_ready) begin
          w_accept     = 1'b1;
          w_next_state = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 8'd1) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_bad   <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      if (w_accept) begin
        r_idx   <= bus.mem_addr[IDX_W-1:0];
        r_wdata <= bus.mem_wdata;
        r_is_wr <= bus.mwr;
        r_bad   <= w_req_bad;
        r_cnt   <= WAIT_L;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (r_state == ST_DONE) begin
        r_ready <= 1'b1;
        r_err   <= r_bad;
        if (!r_bad && !r_is_wr) r_rdata <= r_mem[r_idx];
      end
    end
  end

  // Storage has no reset; rst still suppresses a write that would land on the reset edge.
  assign w_mem_we = !rst && (r_state == ST_DONE) && r_is_wr && !r_bad;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_idx] <= r_wdata;
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.mem_ready = r_ready;
  assign bus.mem_err   = r_err;
  assign bus.mem_busy  = (r_state != ST_IDLE);

endmodule
